// File: rtl/ram_1p_rr_arb.sv
`default_nettype none
// ram_1p_rr_arb: two-host round-robin front end for a single-port RAM macro.
// Rev 1.0 -- one access per cycle, read data returned one cycle after grant.
module ram_1p_rr_arb #(
  parameter  int Width = 32,
  parameter  int Depth = 512,
  localparam int Aw    = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,

  input  logic             h0_req_i,
  input  logic             h0_write_i,
  input  logic [Aw-1:0]    h0_addr_i,
  input  logic [Width-1:0] h0_wdata_i,
  input  logic [Width-1:0] h0_wmask_i,
  output logic             h0_gnt_o,
  output logic             h0_rvalid_o,
  output logic [Width-1:0] h0_rdata_o,

  input  logic             h1_req_i,
  input  logic             h1_write_i,
  input  logic [Aw-1:0]    h1_addr_i,
  input  logic [Width-1:0] h1_wdata_i,
  input  logic [Width-1:0] h1_wmask_i,
  output logic             h1_gnt_o,
  output logic             h1_rvalid_o,
  output logic [Width-1:0] h1_rdata_o,

  output logic             mem_req_o,
  output logic             mem_write_o,
  output logic [Aw-1:0]    mem_addr_o,
  output logic [Width-1:0] mem_wdata_o,
  output logic [Width-1:0] mem_wmask_o,
  input  logic [Width-1:0] mem_rdata_i
);

  logic prio_q,     prio_d;
  logic rd_pend_q,  rd_pend_d;
  logic rd_owner_q, rd_owner_d;
  logic h0_win,     h1_win;

  always_comb begin
    h0_win = h0_req_i & (~h1_req_i | ~prio_q);
    h1_win = h1_req_i & (~h0_req_i |  prio_q);
  end

  // Gating with rst_ni keeps the macro untouched while reset is held.
  assign h0_gnt_o  = h0_win & rst_ni;
  assign h1_gnt_o  = h1_win & rst_ni;
  assign mem_req_o = h0_gnt_o | h1_gnt_o;

  always_comb begin
    mem_write_o = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wmask_o = '0;
    if (h0_gnt_o) begin
      mem_write_o = h0_write_i;
      mem_addr_o  = h0_addr_i;
      mem_wdata_o = h0_wdata_i;
      mem_wmask_o = h0_wmask_i;
    end else if (h1_gnt_o) begin
      mem_write_o = h1_write_i;
      mem_addr_o  = h1_addr_i;
      mem_wdata_o = h1_wdata_i;
      mem_wmask_o = h1_wmask_i;
    end
  end

  always_comb begin
    prio_d = prio_q;
    if (h0_gnt_o) begin
      prio_d = 1'b1;
    end else if (h1_gnt_o) begin
      prio_d = 1'b0;
    end
    rd_pend_d  = (h0_gnt_o & ~h0_write_i) | (h1_gnt_o & ~h1_write_i);
    rd_owner_d = rd_pend_d ? h1_gnt_o : rd_owner_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q     <= 1'b0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
    end else begin
      prio_q     <= prio_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  assign h0_rvalid_o = rd_pend_q & ~rd_owner_q;
  assign h1_rvalid_o = rd_pend_q &  rd_owner_q;
  assign h0_rdata_o  = h0_rvalid_o ? mem_rdata_i : '0;
  assign h1_rdata_o  = h1_rvalid_o ? mem_rdata_i : '0;

endmodule
`default_nettype wire

// File: doc/ram_1p_rr_arb.md
RAM_1P_RR_ARB -- requirements
Module: ram_1p_rr_arb

Interface
REQ-001 SHALL have parameter Width, default 32: data width in bits, matching the sky130 32x512 single-port macro.
REQ-002 SHALL have parameter Depth, default 512: word count; derived localparam Aw = $clog2(Depth).
REQ-003 SHALL have port clk_i, input, 1: sole clock, rising edge.
REQ-004 SHALL have port rst_ni, input, 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have, per host k in {0,1}, port hk_req_i, input, 1: access request, held until granted.
REQ-006 SHALL have hk_write_i, input, 1: 1 = write, 0 = read.
REQ-007 SHALL have hk_addr_i, input, Aw: word address.
REQ-008 SHALL have hk_wdata_i, input, Width: write data.
REQ-009 SHALL have hk_wmask_i, input, Width: per-bit write enable.
REQ-010 SHALL have hk_gnt_o, output, 1: request accepted this cycle.
REQ-011 SHALL have hk_rvalid_o, output, 1: read data valid.
REQ-012 SHALL have hk_rdata_o, output, Width: read data.
REQ-013 SHALL have mem_req_o, mem_write_o, outputs, 1 each, to the RAM primitive's req_i and write_i.
REQ-014 SHALL have mem_addr_o (Aw), mem_wdata_o (Width) and mem_wmask_o (Width), outputs, to the RAM primitive.
REQ-015 SHALL have mem_rdata_i, input, Width: RAM read data, valid one cycle after an accepted read.

Function
REQ-016 SHALL arbitrate between the two hosts combinationally in the same cycle; hk_gnt_o = hk_req_i AND (host k selected).
REQ-017 SHALL keep a 1-bit priority register prio_q (0 = host0 preferred, 1 = host1 preferred).
REQ-018 Arbitration rules:
- Only one host requesting: that host SHALL win regardless of prio_q.
- Both hosts requesting: the host indicated by prio_q SHALL win.
REQ-019 On any grant to host k, prio_q SHALL update to the other host (1-k) at the next edge; with no grant, prio_q SHALL hold.
REQ-020 Fairness: with both hosts requesting continuously, grants SHALL strictly alternate, bounding the wait to 1 cycle.
REQ-021 mem_req_o SHALL equal OR of hk_gnt_o.
REQ-022 mem_write_o, mem_addr_o, mem_wdata_o and mem_wmask_o SHALL mux from the granted host.
REQ-023 When no host is granted, mem_write_o, mem_addr_o, mem_wdata_o and mem_wmask_o SHALL drive zero.
REQ-024 On each granted read, the block SHALL register rd_pend_q=1 and rd_owner_q=k; on every other cycle rd_pend_q SHALL clear to 0.
REQ-025 hk_rvalid_o SHALL equal rd_pend_q AND (rd_owner_q==k), exactly one cycle after the grant; writes SHALL produce no rvalid.
REQ-026 hk_rdata_o SHALL equal mem_rdata_i when hk_rvalid_o is 1, else all-zero.
REQ-027 Back-to-back reads SHALL be fully pipelined: a new grant in cycle N+1 coexists with rvalid for the cycle-N grant; throughput is 1 access/cycle.
REQ-028 Accesses from different hosts to the same address in consecutive cycles SHALL execute in grant order; read-after-write returns the new data.
REQ-029 A request dropped before grant SHALL be allowed and have no effect; the block performs no payload-stability checking.

Reset
REQ-030 While rst_ni=0:
- prio_q=0, rd_pend_q=0, rd_owner_q=0.
- All hk_gnt_o, hk_rvalid_o and mem_req_o SHALL be forced to 0 regardless of requests.
- All data outputs SHALL be zero.
REQ-031 Reset asserted between a read grant and its rvalid SHALL drop the pending rvalid; no rvalid appears after reset release.
REQ-032 The first arbitration after reset release SHALL prefer host0.

Verification
REQ-033 Single read: h0 read addr 0x005 (RAM holds 0x1234_5678) -> h0_gnt=1 cycle N, mem_req=1, h0_rvalid=1 with rdata 0x1234_5678 at N+1, h1_rvalid=0.
REQ-034 Contention: both hosts request continuously from reset for 6 cycles -> grant order h0,h1,h0,h1,h0,h1.
REQ-035 Write then read: h1 writes 0xDEAD_BEEF to 0x1FF (mask all-ones), then h0 reads 0x1FF -> h0_rdata=0xDEAD_BEEF, no rvalid for the write.
REQ-036 Masked write: mask 0x0000_FFFF writes 0xAAAA_5555 over 0xFFFF_0000 -> subsequent read returns 0xFFFF_5555.
REQ-037 Reset mid-read: h0 read granted, rst_ni low before next edge -> h0_rvalid stays 0; after release h0 is preferred when both request.
REQ-038 Idle: no requests for 10 cycles -> mem_req=0, all gnt/rvalid 0, prio_q unchanged.
